memory_stage: RTL

Pipeline stage directly downstream of the execute stage. Consumes the registered ALU result, PC, LDM value, register operands and memory control bits. Performs data-memory load/store and stack push/pop, including two-cycle 32-bit PC transfers. Presents a registered bundle to write-back and a PC-load request for returns.

---
 rtl/mem_stage_pkg.sv | 37 +++
 rtl/data_memory.sv | 22 ++
 rtl/memory_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: select encodings, FSM states and the
// registered bundle handed to write-back.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    RESULT = 2'b00,
    STACK  = 2'b01,
    RDEST  = 2'b10
  } addr_sel_e;

  typedef enum logic [1:0] {
    RSRC  = 2'b00,
    PC32  = 2'b01,
    FLAGS = 2'b10
  } wsrc_sel_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } mem_state_e;

  // Sliced down to the stack-pointer width where it is used.
  localparam logic [15:0] SP_RESET = '1;

  typedef struct packed {
    logic [15:0] mem_data;
    logic [15:0] result;
    logic [15:0] ldm;
    logic        reg_write;
    logic        pc_enable;
    logic [1:0]  wb_sel;
    logic        pc_load;
    logic [31:0] new_pc;
    logic [2:0]  cond;
  } wb_bundle_t;

endpackage

// File: rtl/data_memory.sv
// 2^ADDR_W x 16 data memory: synchronous write, combinational read.
module data_memory #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o
);

  logic [15:0] mem_q [0:(1<<ADDR_W)-1];

  // NOTE: the storage array has no reset; clearing it would need a per-word
  // reset network, and software never relies on its power-up contents.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: loads/stores, stack push/pop and two-cycle 32-bit
// PC push/pop, with a registered bundle towards write-back.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] result,
  input  logic [31:0] PC,
  input  logic [15:0] LDM_value,
  input  logic [15:0] read_data1,
  input  logic [15:0] read_data2,
  input  logic [2:0]  flags,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_push,
  input  logic        mem_pop,
  input  logic [1:0]  memory_address_select,
  input  logic [1:0]  memory_write_src_select,
  input  logic        reg_write,
  input  logic        pc_enable,
  input  logic [1:0]  wb_sel,
  output logic        stall_out,
  output logic [15:0] mem_data_out,
  output logic [15:0] result_out,
  output logic [15:0] LDM_value_out,
  output logic        reg_write_out,
  output logic        pc_enable_out,
  output logic [1:0]  wb_sel_out,
  output logic        pc_load_out,
  output logic [31:0] new_PC_out,
  output logic [2:0]  conditions_from_memory_pop
);

  localparam logic [ADDR_W-1:0] SP_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SP_TWO  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] SP_INIT = SP_RESET[ADDR_W-1:0];

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [15:0]       lo_word_q, lo_word_d;
  logic              op_pop_q, op_pop_d;
  wb_bundle_t        wb_q, wb_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              stall;

  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;
  logic              is_push, is_pop, dbl_push, dbl_pop, flag_pop, is_store, is_load;
  logic              unused_bits;

  // Push wins over pop; any stack op overrides plain load/store.
  assign is_push  = mem_push;
  assign is_pop   = mem_pop && !mem_push;
  assign dbl_push = is_push && (memory_write_src_select == PC32);
  assign dbl_pop  = is_pop && pc_enable;
  assign flag_pop = is_pop && !pc_enable && (memory_write_src_select == FLAGS);
  assign is_store = mem_write && !mem_push && !mem_pop;
  assign is_load  = mem_read && !mem_push && !mem_pop;

  assign unused_bits = ^{result, read_data1};

  always_comb begin
    case (memory_address_select)
      STACK:   sel_addr = sp_q;
      RDEST:   sel_addr = read_data1[ADDR_W-1:0];
      default: sel_addr = result[ADDR_W-1:0];
    endcase
    case (memory_write_src_select)
      PC32:    sel_wdata = PC[15:0];
      FLAGS:   sel_wdata = {13'b0, flags};
      default: sel_wdata = read_data2;
    endcase
  end

  data_memory #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    lo_word_d = lo_word_q;
    op_pop_d  = op_pop_q;
    mem_we    = 1'b0;
    mem_addr  = sel_addr;
    mem_wdata = sel_wdata;
    stall     = 1'b0;

    wb_d           = wb_q;
    wb_d.result    = result;
    wb_d.ldm       = LDM_value;
    wb_d.wb_sel    = wb_sel;
    wb_d.pc_load   = 1'b0;

    case (state_q)
      IDLE: begin
        // Stack ops address the stack whatever the address select says.
        if (is_push) begin
          mem_addr = sp_q;
          mem_we   = 1'b1;
          if (dbl_push) begin
            mem_wdata = PC[31:16];
            lo_word_d = PC[15:0];
            op_pop_d  = 1'b0;
            stall     = 1'b1;
            state_d   = SECOND;
          end else begin
            sp_d = sp_q - SP_ONE;
          end
        end else if (is_pop) begin
          mem_addr = sp_q + SP_ONE;
          if (dbl_pop) begin
            lo_word_d = mem_rdata;
            op_pop_d  = 1'b1;
            stall     = 1'b1;
            state_d   = SECOND;
          end else begin
            sp_d          = sp_q + SP_ONE;
            wb_d.mem_data = mem_rdata;
            if (flag_pop) wb_d.cond = mem_rdata[2:0];
          end
        end else begin
          mem_we = is_store;
          if (is_load) wb_d.mem_data = mem_rdata;
        end
      end
      SECOND: begin
        state_d = IDLE;
        if (op_pop_q) begin
          mem_addr     = sp_q + SP_TWO;
          sp_d         = sp_q + SP_TWO;
          wb_d.pc_load = 1'b1;
          wb_d.new_pc  = {mem_rdata, lo_word_q};
        end else begin
          mem_addr  = sp_q - SP_ONE;
          mem_wdata = lo_word_q;
          mem_we    = 1'b1;
          sp_d      = sp_q - SP_TWO;
        end
      end
      default: state_d = IDLE;
    endcase

    // The first cycle of a double op is a bubble towards write-back.
    wb_d.reg_write = reg_write && !stall;
    wb_d.pc_enable = pc_enable && !stall;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sp_q      <= SP_INIT;
      lo_word_q <= '0;
      op_pop_q  <= 1'b0;
      wb_q      <= '0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      lo_word_q <= lo_word_d;
      op_pop_q  <= op_pop_d;
      wb_q      <= wb_d;
    end
  end

  assign stall_out                  = stall && !reset;
  assign mem_data_out               = wb_q.mem_data;
  assign result_out                 = wb_q.result;
  assign LDM_value_out              = wb_q.ldm;
  assign reg_write_out              = wb_q.reg_write;
  assign pc_enable_out              = wb_q.pc_enable;
  assign wb_sel_out                 = wb_q.wb_sel;
  assign pc_load_out                = wb_q.pc_load;
  assign new_PC_out                 = wb_q.new_pc;
  assign conditions_from_memory_pop = wb_q.cond;

endmodule
